// File: rtl/seg7_scan_driver.sv
// ============================================================================
// seg7_scan_driver
// ----------------------------------------------------------------------------
// Time-multiplexed driver for DIGITS common-anode seven-segment digits that
// share one active-low segment bus. A refresh prescaler holds each digit lit
// for CLK_DIV cycles, and a scan counter walks the digits from 0 (rightmost)
// up to DIGITS-1. Display data comes from a frame snapshot that is captured
// in two situations: when the scan wraps from the last digit back to digit 0,
// and on the first enabled cycle after reset. As a result, a half-updated
// `value` never shows up torn across one refresh frame.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   scan enable; low freezes the scan and darkens the display
//   value       in   4*DIGITS hex nibbles, digit k = value[4k+3:4k]
//   dp_mask     in   DIGITS decimal-point enables (1 = lit)
//   blank_mask  in   DIGITS forced-dark enables (1 = dark)
//   lz_suppress in   1 = blank leading zero digits (digit 0 always shown)
//   an          out  DIGITS digit enables, active low, at most one low
//   seg         out  8 segments, active low, bit0=a .. bit6=g, bit7=dp
//   frame_tick  out  one-cycle pulse following each snapshot
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 50000,
  parameter int IDX_W   = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  // CLK_DIV = 1 would otherwise yield a zero-width counter.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // --------------------------------------------------------------------------
  // Hex nibble to segments a..g, active low (bit0 = a, bit6 = g).
  // --------------------------------------------------------------------------
  function automatic logic [6:0] enc7(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'b1111111;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b0100111;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]      div_cnt_q,      div_cnt_d;
  logic [IDX_W-1:0]      idx_q,          idx_d;
  logic                  load_pending_q, load_pending_d;

  logic [4*DIGITS-1:0]   snap_val_q,     snap_val_d;
  logic [DIGITS-1:0]     snap_dp_q,      snap_dp_d;
  logic [DIGITS-1:0]     snap_blank_q,   snap_blank_d;
  logic                  snap_lz_q,      snap_lz_d;

  logic [DIGITS-1:0]     an_q,           an_d;
  logic [7:0]            seg_q,          seg_d;
  logic                  frame_tick_q,   frame_tick_d;

  // --------------------------------------------------------------------------
  // Scan control decode
  // --------------------------------------------------------------------------
  logic step;
  logic idx_at_last;
  logic wrap;
  logic take_snap;

  assign step        = (div_cnt_q == DIV_LAST);
  assign idx_at_last = (idx_q == IDX_LAST);
  assign wrap        = step && idx_at_last;
  // The pending post-reset load and a wrap in the same cycle merge into one
  // snapshot and one frame_tick.
  assign take_snap   = wrap || load_pending_q;

  // --------------------------------------------------------------------------
  // Leading-zero detection on the snapshot.
  // lz_chain[k] is 1 when every nibble from k up to DIGITS-1 is zero, so a
  // digit is a leading zero exactly when its chain bit is set.
  // --------------------------------------------------------------------------
  logic [DIGITS:0] lz_chain;

  always_comb begin
    lz_chain         = '0;
    lz_chain[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_chain[k] = lz_chain[k+1] & (snap_val_q[4*k +: 4] == 4'h0);
    end
  end

  // --------------------------------------------------------------------------
  // Current digit: nibble, blanking and decimal point
  // --------------------------------------------------------------------------
  logic [3:0] nib_cur;
  logic       lz_blank;
  logic       blank_cur;
  logic       dp_cur;

  assign nib_cur   = snap_val_q[{idx_q, 2'b00} +: 4];
  // Digit 0 is exempt so that an all-zero value still shows a single "0".
  assign lz_blank  = snap_lz_q && (idx_q != '0) && lz_chain[idx_q];
  assign blank_cur = snap_blank_q[idx_q] || lz_blank;
  assign dp_cur    = snap_dp_q[idx_q];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    div_cnt_d      = div_cnt_q;
    idx_d          = idx_q;
    load_pending_d = load_pending_q;
    snap_val_d     = snap_val_q;
    snap_dp_d      = snap_dp_q;
    snap_blank_d   = snap_blank_q;
    snap_lz_d      = snap_lz_q;
    // Dark and idle unless the scan is enabled.
    an_d           = '1;
    seg_d          = 8'hFF;
    frame_tick_d   = 1'b0;

    if (en) begin
      if (step) begin
        div_cnt_d = '0;
        idx_d     = idx_at_last ? '0 : idx_q + IDX_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end

      if (take_snap) begin
        snap_val_d     = value;
        snap_dp_d      = dp_mask;
        snap_blank_d   = blank_mask;
        snap_lz_d      = lz_suppress;
        load_pending_d = 1'b0;
        frame_tick_d   = 1'b1;
      end

      // Outputs follow the pre-edge idx and snapshot, so they trail idx by one
      // cycle. A blanked digit also keeps its decimal point dark.
      if (!blank_cur) begin
        an_d  = ~(DIGITS'(1) << idx_q);
        seg_d = {~dp_cur, enc7(nib_cur)};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      idx_q          <= '0;
      load_pending_q <= 1'b1;
      snap_val_q     <= '0;
      snap_dp_q      <= '0;
      snap_blank_q   <= '0;
      snap_lz_q      <= 1'b0;
      an_q           <= '1;
      seg_q          <= 8'hFF;
      frame_tick_q   <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      idx_q          <= idx_d;
      load_pending_q <= load_pending_d;
      snap_val_q     <= snap_val_d;
      snap_dp_q      <= snap_dp_d;
      snap_blank_q   <= snap_blank_d;
      snap_lz_q      <= snap_lz_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// tb_seg7_scan_driver
// ----------------------------------------------------------------------------
// Directed bench for seg7_scan_driver with DIGITS=4, CLK_DIV=4. Each digit
// slot therefore lasts 4 cycles, and a frame lasts 16 cycles. Inputs change
// and outputs are sampled on the falling edge. A table of whole-frame vectors
// is followed by hand-written sequences for the start-up load, a mid-frame
// value change, an enable pause and a mid-scan reset.
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    dp_mask;
  logic [DIGITS-1:0]    blank_mask;
  logic                 lz_suppress;
  logic [DIGITS-1:0]    an;
  logic [7:0]           seg;
  logic                 frame_tick;

  seg7_scan_driver #(
    .DIGITS (DIGITS),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .lz_suppress(lz_suppress),
    .an         (an),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // One frame of expectations; packed arrays are indexed by digit (element 0
  // is digit 0, listed last in the concatenations below).
  typedef struct {
    logic [15:0]      value;
    logic [3:0]       dp;
    logic [3:0]       blank;
    logic             lz;
    logic [3:0][3:0]  an;
    logic [3:0][7:0]  seg;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Four cycles of one digit slot; ft_last expects the frame_tick on its
  // final cycle (the cycle following a wrap snapshot).
  task automatic check_slot(input string name, input logic [3:0] ean,
                            input logic [7:0] eseg, input bit ft_last);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk({name, ".an"}, 32'(an), 32'(ean));
      chk({name, ".seg"}, 32'(seg), 32'(eseg));
      chk({name, ".ft"}, 32'(frame_tick), 32'(ft_last && (c == 3)));
    end
  endtask

  task automatic check_dark(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk({name, ".an"}, 32'(an), 32'hF);
      chk({name, ".seg"}, 32'(seg), 32'hFF);
      chk({name, ".ft"}, 32'(frame_tick), 32'h0);
    end
  endtask

  task automatic wait_ft(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 64);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL %s.wait_ft: got no frame_tick within %0d cycles", name, n);
    end
  endtask

  initial begin
    //            value     dp       blank    lz    an (d3..d0)                          seg (d3..d0)
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0, {4'b0111,4'b1011,4'b1101,4'b1110}, {8'hF9,8'hA4,8'h88,8'h8E}};
    vecs[1] = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {4'b0111,4'b1011,4'b1101,4'b1110}, {8'hC0,8'hC0,8'hC0,8'hC0}};
    vecs[2] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {4'b1111,4'b1111,4'b1101,4'b1110}, {8'hFF,8'hFF,8'h92,8'hC0}};
    vecs[3] = '{16'h0000, 4'b0001, 4'b0000, 1'b1, {4'b1111,4'b1111,4'b1111,4'b1110}, {8'hFF,8'hFF,8'hFF,8'h40}};
    vecs[4] = '{16'h12AF, 4'b0100, 4'b0100, 1'b0, {4'b0111,4'b1111,4'b1101,4'b1110}, {8'hF9,8'hFF,8'h88,8'h8E}};
    vecs[5] = '{16'h3E9C, 4'b1010, 4'b0000, 1'b0, {4'b0111,4'b1011,4'b1101,4'b1110}, {8'h30,8'h86,8'h10,8'hA7}};
    vecs[6] = '{16'h0405, 4'b0000, 4'b0000, 1'b1, {4'b1111,4'b1011,4'b1101,4'b1110}, {8'hFF,8'h99,8'hC0,8'h92}};
    vecs[7] = '{16'h6D7B, 4'b0000, 4'b0000, 1'b1, {4'b0111,4'b1011,4'b1101,4'b1110}, {8'h82,8'hA1,8'hF8,8'h83}};
    vecs[8] = '{16'h0001, 4'b0000, 4'b0001, 1'b1, {4'b1111,4'b1111,4'b1111,4'b1111}, {8'hFF,8'hFF,8'hFF,8'hFF}};
    vecs[9] = '{16'h8400, 4'b0000, 4'b0000, 1'b0, {4'b0111,4'b1011,4'b1101,4'b1110}, {8'h80,8'h99,8'hC0,8'hC0}};

    rst         = 1'b1;
    en          = 1'b0;
    value       = '0;
    dp_mask     = '0;
    blank_mask  = '0;
    lz_suppress = 1'b0;

    // Reset state.
    check_dark("reset", 2);

    // Released but not enabled: still dark, no load yet.
    @(negedge clk);
    rst = 1'b0;
    check_dark("idle", 2);

    // First enabled cycle takes the snapshot; the tick follows one cycle later.
    // That first output cycle still reflects the reset snapshot, so only an
    // and the tick are checked there.
    en    = 1'b1;
    value = 16'h12AF;
    @(negedge clk);
    chk("start.ft", 32'(frame_tick), 32'h1);
    chk("start.an", 32'(an), 32'hE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("start.d0.an", 32'(an), 32'hE);
      chk("start.d0.seg", 32'(seg), 32'h8E);
      chk("start.d0.ft", 32'(frame_tick), 32'h0);
    end
    check_slot("start.d1", 4'b1101, 8'h88, 1'b0);
    check_slot("start.d2", 4'b1011, 8'hA4, 1'b0);
    check_slot("start.d3", 4'b0111, 8'hF9, 1'b1);

    // Change value mid-frame: 12AF stays until the wrap.
    check_slot("tear.d0", 4'b1110, 8'h8E, 1'b0);
    check_slot("tear.d1", 4'b1101, 8'h88, 1'b0);
    value = 16'h0000;
    check_slot("tear.d2", 4'b1011, 8'hA4, 1'b0);
    check_slot("tear.d3", 4'b0111, 8'hF9, 1'b1);
    check_slot("zero.d0", 4'b1110, 8'hC0, 1'b0);
    check_slot("zero.d1", 4'b1101, 8'hC0, 1'b0);
    check_slot("zero.d2", 4'b1011, 8'hC0, 1'b0);
    check_slot("zero.d3", 4'b0111, 8'hC0, 1'b1);

    // Whole-frame table.
    for (int i = 0; i < NVEC; i++) begin
      value       = vecs[i].value;
      dp_mask     = vecs[i].dp;
      blank_mask  = vecs[i].blank;
      lz_suppress = vecs[i].lz;
      wait_ft($sformatf("vec%0d", i));
      for (int s = 0; s < 4; s++) begin
        check_slot($sformatf("vec%0d.d%0d", i, s), vecs[i].an[s], vecs[i].seg[s], s == 3);
      end
    end

    // Enable pause mid-slot: dark while paused, then the held idx and div
    // count resume (two remaining digit-0 cycles, then digit 1).
    value       = 16'h12AF;
    dp_mask     = '0;
    blank_mask  = '0;
    lz_suppress = 1'b0;
    wait_ft("pause");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("pause.pre.an", 32'(an), 32'hE);
      chk("pause.pre.seg", 32'(seg), 32'h8E);
    end
    en = 1'b0;
    check_dark("pause.off", 10);
    en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("pause.post.an", 32'(an), 32'hE);
      chk("pause.post.seg", 32'(seg), 32'h8E);
    end
    check_slot("pause.d1", 4'b1101, 8'h88, 1'b0);

    // Reset pulse mid-scan with new data waiting: dark next cycle, then a
    // fresh load and a scan restarting at digit 0.
    rst   = 1'b1;
    value = 16'h0050;
    check_dark("midrst", 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.ft", 32'(frame_tick), 32'h1);
    chk("midrst.an", 32'(an), 32'hE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst.d0.an", 32'(an), 32'hE);
      chk("midrst.d0.seg", 32'(seg), 32'hC0);
      chk("midrst.d0.ft", 32'(frame_tick), 32'h0);
    end
    check_slot("midrst.d1", 4'b1101, 8'h92, 1'b0);
    check_slot("midrst.d2", 4'b1011, 8'hC0, 1'b0);
    check_slot("midrst.d3", 4'b0111, 8'hC0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
